// File: rtl/branch_predictor.sv
// branch_predictor: fetch-side direct-mapped BTB with 2-bit saturating
// counters, trained from execute-stage branch resolution.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   if_pc              fetch PC to predict
//   if_pred_taken      predicted taken (combinational lookup)
//   if_pred_target     predicted target, if_pc+4 when not predicted taken
//   ex_valid           valid instruction in execute this cycle
//   ex_is_branch       instruction is cond. branch, JAL or JALR
//   ex_pc              PC of the execute-stage instruction
//   ex_taken           resolved taken
//   ex_target          resolved target
//   ex_pred_taken      prediction carried with this instruction
//   ex_pred_target     predicted target carried with this instruction
//   ex_mispredict      flush/redirect request (combinational)
//   ex_redirect_pc     ex_taken ? ex_target : ex_pc+4
//   perf_branches      (BP_PERF_CNT_EN only) count of resolved branches
//   perf_mispredicts   (BP_PERF_CNT_EN only) count of mispredict cycles
//
// Optional feature macro: BP_PERF_CNT_EN

module branch_predictor #(
    parameter int         ENTRIES  = 64,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        ex_mispredict,
    output logic [31:0] ex_redirect_pc
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic             valid [ENTRIES];
    logic [TAG_W-1:0] tag   [ENTRIES];
    logic [31:0]      tgt   [ENTRIES];
    logic [1:0]       cnt   [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_tag_eq;
    logic             ex_hit;
    logic             train;
    logic             kill;

    // Low PC bits never index or tag the table.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^{if_pc[1:0], ex_pc[1:0]};

    // Lookup: reads the registered table, so a same-cycle update is not seen.
    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[31:IDX_W+2];
    assign if_hit = valid[if_idx] && (tag[if_idx] == if_tag);

    assign if_pred_taken  = if_hit && cnt[if_idx][1];
    assign if_pred_target = if_pred_taken ? tgt[if_idx] : if_pc + 32'd4;

    assign ex_idx    = ex_pc[IDX_W+1:2];
    assign ex_tag    = ex_pc[31:IDX_W+2];
    assign ex_tag_eq = tag[ex_idx] == ex_tag;
    assign ex_hit    = valid[ex_idx] && ex_tag_eq;
    assign train     = ex_valid && ex_is_branch;
    // A non-branch that was predicted taken hit an aliased/stale entry.
    assign kill      = ex_valid && !ex_is_branch && ex_pred_taken;

    always_comb begin
        ex_mispredict = 1'b0;
        if (ex_valid) begin
            if (ex_is_branch) begin
                ex_mispredict = (ex_taken != ex_pred_taken) ||
                                (ex_taken && ex_pred_taken &&
                                 (ex_target != ex_pred_target));
            end else begin
                ex_mispredict = ex_pred_taken;
            end
        end
    end

    assign ex_redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
                tag[i]   <= '0;
                tgt[i]   <= '0;
                cnt[i]   <= CNT_INIT;
            end
        end else if (train) begin
            if (ex_hit) begin
                if (ex_taken) begin
                    if (cnt[ex_idx] != 2'b11) begin
                        cnt[ex_idx] <= cnt[ex_idx] + 2'd1;
                    end
                    tgt[ex_idx] <= ex_target;
                end else if (cnt[ex_idx] != 2'b00) begin
                    cnt[ex_idx] <= cnt[ex_idx] - 2'd1;
                end
            end else if (ex_taken) begin
                valid[ex_idx] <= 1'b1;
                tag[ex_idx]   <= ex_tag;
                tgt[ex_idx]   <= ex_target;
                cnt[ex_idx]   <= 2'b10;
            end
        end else if (kill && ex_tag_eq) begin
            valid[ex_idx] <= 1'b0;
        end
    end

`ifdef BP_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (train) begin
                perf_branches <= perf_branches + 32'd1;
            end
            if (ex_mispredict) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed table-driven checks of branch_predictor
// plus hand-written reset and counter sequences.

module tb_branch_predictor;

    localparam int ENT = 64;
    localparam logic [31:0] AL = 32'h100 + 4 * ENT;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        ex_mispredict;
    logic [31:0] ex_redirect_pc;
`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(ENT), .CNT_INIT(2'b01)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .if_pred_target (if_pred_target),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .ex_mispredict  (ex_mispredict),
        .ex_redirect_pc (ex_redirect_pc)
`ifdef BP_PERF_CNT_EN
        ,
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic        ev;
        logic        eb;
        logic [31:0] epc;
        logic        et;
        logic [31:0] etg;
        logic        ept;
        logic [31:0] eptg;
        logic        xpt;
        logic [31:0] xtg;
        logic        xmis;
        logic [31:0] xred;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        logic [31:0] pc, logic ev, logic eb, logic [31:0] epc,
        logic et, logic [31:0] etg, logic ept, logic [31:0] eptg,
        logic xpt, logic [31:0] xtg, logic xmis, logic [31:0] xred);
        vec_t r;
        r.pc = pc; r.ev = ev; r.eb = eb; r.epc = epc;
        r.et = et; r.etg = etg; r.ept = ept; r.eptg = eptg;
        r.xpt = xpt; r.xtg = xtg; r.xmis = xmis; r.xred = xred;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        if_pc          = x.pc;
        ex_valid       = x.ev;
        ex_is_branch   = x.eb;
        ex_pc          = x.epc;
        ex_taken       = x.et;
        ex_target      = x.etg;
        ex_pred_taken  = x.ept;
        ex_pred_target = x.eptg;
    endtask

    task automatic idle(input logic [31:0] pc);
        drive(mk(pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic look(input string nm, input logic pt,
                        input logic [31:0] tg);
        chk({nm, "_pt"}, {31'd0, if_pred_taken}, {31'd0, pt});
        chk({nm, "_tg"}, if_pred_target, tg);
    endtask

    initial begin
        // pc, ev, eb, epc, et, etg, ept, eptg | pt, tgt, mis, redirect
        vq.push_back(mk(32'h100, 0,0, 32'h0,   0,32'h0,  0,32'h0,   0,32'h104, 0,32'h4));
        vq.push_back(mk(32'h100, 1,1, 32'h100, 1,32'h200,0,32'h0,   0,32'h104, 1,32'h200));
        vq.push_back(mk(32'h100, 0,0, 32'h0,   0,32'h0,  0,32'h0,   1,32'h200, 0,32'h4));
        vq.push_back(mk(32'h100, 1,1, 32'h100, 0,32'h0,  1,32'h200, 1,32'h200, 1,32'h104));
        vq.push_back(mk(32'h100, 1,1, 32'h100, 0,32'h0,  0,32'h0,   0,32'h104, 0,32'h104));
        vq.push_back(mk(32'h100, 1,1, 32'h100, 0,32'h0,  0,32'h0,   0,32'h104, 0,32'h104));
        vq.push_back(mk(32'h100, 1,1, 32'h100, 1,32'h200,0,32'h0,   0,32'h104, 1,32'h200));
        vq.push_back(mk(32'h100, 1,1, 32'h100, 1,32'h200,0,32'h0,   0,32'h104, 1,32'h200));
        vq.push_back(mk(32'h100, 1,1, 32'h100, 1,32'h200,1,32'h200, 1,32'h200, 0,32'h200));
        vq.push_back(mk(32'h100, 1,1, 32'h100, 1,32'h200,1,32'h200, 1,32'h200, 0,32'h200));
        vq.push_back(mk(32'h100, 1,1, 32'h100, 0,32'h0,  1,32'h200, 1,32'h200, 1,32'h104));
        vq.push_back(mk(32'h100, 0,0, 32'h0,   0,32'h0,  0,32'h0,   1,32'h200, 0,32'h4));
        vq.push_back(mk(32'h100, 1,1, 32'h100, 0,32'h0,  1,32'h200, 1,32'h200, 1,32'h104));
        vq.push_back(mk(32'h100, 0,0, 32'h0,   0,32'h0,  0,32'h0,   0,32'h104, 0,32'h4));
        vq.push_back(mk(32'h100, 1,1, 32'h100, 1,32'h300,0,32'h0,   0,32'h104, 1,32'h300));
        vq.push_back(mk(32'h100, 1,1, 32'h100, 1,32'h300,1,32'h200, 1,32'h300, 1,32'h300));
        vq.push_back(mk(32'h100, 1,0, AL,      0,32'h0,  1,32'h500, 1,32'h300, 1,AL+32'h4));
        vq.push_back(mk(AL,      0,0, 32'h0,   0,32'h0,  0,32'h0,   0,AL+32'h4,0,32'h4));
        vq.push_back(mk(32'h100, 0,0, 32'h0,   0,32'h0,  0,32'h0,   1,32'h300, 0,32'h4));
        vq.push_back(mk(32'h100, 1,0, 32'h100, 0,32'h0,  1,32'h300, 1,32'h300, 1,32'h104));
        vq.push_back(mk(32'h100, 0,0, 32'h0,   0,32'h0,  0,32'h0,   0,32'h104, 0,32'h4));
        vq.push_back(mk(32'h100, 0,1, 32'h100, 1,32'h500,0,32'h0,   0,32'h104, 0,32'h500));
        vq.push_back(mk(32'h100, 0,0, 32'h0,   0,32'h0,  0,32'h0,   0,32'h104, 0,32'h4));
        vq.push_back(mk(32'hFFFF_FFFC, 1,1, 32'hFFFF_FFFC, 0,32'h0, 1,32'h40,
                        0,32'h0, 1,32'h0));
        vq.push_back(mk(32'hFFFF_FFFC, 1,0, 32'h80, 0,32'h0, 0,32'h0,
                        0,32'h0, 0,32'h84));

        rst = 1'b1;
        idle(32'h100);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i]);
            #1;
            chk($sformatf("v%0d_pt", i), {31'd0, if_pred_taken}, {31'd0, vq[i].xpt});
            chk($sformatf("v%0d_tg", i), if_pred_target, vq[i].xtg);
            chk($sformatf("v%0d_mis", i), {31'd0, ex_mispredict}, {31'd0, vq[i].xmis});
            chk($sformatf("v%0d_red", i), ex_redirect_pc, vq[i].xred);
        end

        // Train 0x100, then reset with an update presented: history is lost
        // and the reset-cycle update is dropped.
        @(negedge clk);
        drive(mk(32'h100, 1,1, 32'h100, 1,32'h200, 0,32'h0, 0,0,0,0));
        @(negedge clk);
        idle(32'h100);
        #1;
        look("trained", 1'b1, 32'h200);
        @(negedge clk);
        rst = 1'b1;
        drive(mk(32'h100, 1,1, 32'h100, 1,32'h600, 0,32'h0, 0,0,0,0));
        @(negedge clk);
        rst = 1'b0;
        idle(32'h100);
        #1;
        look("post_rst", 1'b0, 32'h104);

        // Three branches, one mispredict, counted from reset.
        @(negedge clk);
        drive(mk(32'h100, 1,1, 32'h100, 1,32'h200, 0,32'h0, 0,0,0,0));
        @(negedge clk);
        drive(mk(32'h100, 1,1, 32'h100, 1,32'h200, 1,32'h200, 0,0,0,0));
        #1;
        look("cnt10", 1'b1, 32'h200);
        @(negedge clk);
        drive(mk(32'h100, 1,1, 32'h100, 1,32'h200, 1,32'h200, 0,0,0,0));
        @(negedge clk);
        idle(32'h100);
        #1;
        look("cnt11", 1'b1, 32'h200);
`ifdef BP_PERF_CNT_EN
        chk("perf_branches", perf_branches, 32'd3);
        chk("perf_mispredicts", perf_mispredicts, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
